run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_seq_pkg.sv | 19 +
 rtl/run_seq_timer.sv | 40 ++++
 rtl/run_sequencer.sv | 177 +++++++++++++++++
 tb/tb_run_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared types and default parameter values for the run sequencer.
//   state_e         - sequencer state encoding
//   *_DEF           - default values for N_CH, RST_CYCLES, STAGGER, MAX_CYCLES
package run_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam int unsigned N_CH_DEF       = 2;
    localparam int unsigned RST_CYCLES_DEF = 1;
    localparam int unsigned STAGGER_DEF    = 4;
    localparam int unsigned MAX_CYCLES_DEF = 1000;

endpackage

// File: rtl/run_seq_timer.sv
// run_seq_timer: loadable down-counter with zero flag.
//   clk, reset - rising-edge clock, synchronous active-high reset
//   load       - load counter with load_val (has priority over dec)
//   load_val   - value to load
//   dec        - decrement by one; holds at zero
//   zero       - counter currently equals zero
module run_seq_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: drives per-core active-low resets through IDLE -> ASSERT ->
// RELEASE (staggered per channel) -> RUN -> DONE, counting RUN cycles.
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   start        - pulse: begin a sequence (from IDLE or DONE)
//   stop         - abort to IDLE (done/timeout/cycle_count kept)
//   halt_req     - core completion, honoured only in RUN
//   core_resetn  - per-channel active-low reset
//   running      - high while in RUN
//   done         - sticky: run ended by halt_req
//   timeout      - sticky: run ended by reaching MAX_CYCLES
//   cycle_count  - RUN cycles elapsed, saturating at MAX_CYCLES
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned N_CH       = N_CH_DEF,
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
    parameter int unsigned STAGGER    = STAGGER_DEF,
    parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int unsigned CNT_W      = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             halt_req,
    output logic [N_CH-1:0]  core_resetn,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    // One timer serves both phases, so size it for the longer interval.
    localparam int unsigned TMR_MAX = (RST_CYCLES > STAGGER) ? RST_CYCLES : STAGGER;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] STG_LOAD = TMR_W'((STAGGER == 0) ? 0 : STAGGER - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

    state_e            state_q, state_d;
    logic [N_CH-1:0]   core_resetn_q, core_resetn_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]  count_inc;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_load_val;
    logic              tmr_dec;
    logic              tmr_zero;

    run_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign count_inc = (cycle_count_q == CNT_MAX) ? cycle_count_q
                                                  : cycle_count_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        core_resetn_d = core_resetn_q;
        running_d     = running_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;
        tmr_load      = 1'b0;
        tmr_load_val  = '0;
        tmr_dec       = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d       = ST_ASSERT;
                    core_resetn_d = '0;
                    running_d     = 1'b0;
                    done_d        = 1'b0;
                    timeout_d     = 1'b0;
                    cycle_count_d = '0;
                    tmr_load      = 1'b1;
                    tmr_load_val  = RST_LOAD;
                end
            end
            ST_ASSERT: begin
                core_resetn_d = '0;
                if (tmr_zero) begin
                    state_d       = ST_RELEASE;
                    core_resetn_d = (STAGGER == 0) ? '1 : N_CH'(1);
                    tmr_load      = 1'b1;
                    tmr_load_val  = STG_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RELEASE: begin
                // Channels release in index order, so shifting a one in
                // always frees the lowest still-held channel.
                if (&core_resetn_q) begin
                    state_d   = ST_RUN;
                    running_d = 1'b1;
                end else if (tmr_zero) begin
                    core_resetn_d = (core_resetn_q << 1) | N_CH'(1);
                    tmr_load      = 1'b1;
                    tmr_load_val  = STG_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RUN: begin
                // Counting on every RUN edge, including the exit edge, makes
                // a halt in the Nth RUN cycle report N.
                cycle_count_d = count_inc;
                if (halt_req) begin
                    state_d       = ST_DONE;
                    done_d        = 1'b1;
                    running_d     = 1'b0;
                    core_resetn_d = '0;
                end else if (count_inc == CNT_MAX) begin
                    state_d       = ST_DONE;
                    timeout_d     = 1'b1;
                    running_d     = 1'b0;
                    core_resetn_d = '0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                core_resetn_d = '0;
                running_d     = 1'b0;
            end
        endcase

        // stop overrides everything decided above; status is kept.
        if (stop) begin
            state_d       = ST_IDLE;
            core_resetn_d = '0;
            running_d     = 1'b0;
            done_d        = done_q;
            timeout_d     = timeout_q;
            cycle_count_d = cycle_count_q;
            tmr_load      = 1'b0;
            tmr_dec       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            core_resetn_q <= '0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            core_resetn_q <= core_resetn_d;
            running_q     <= running_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign core_resetn = core_resetn_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_sequencer.sv
`timescale 1ns/1ps
// tb_run_sequencer: three run_sequencer configurations checked against a
// timeline model every cycle, plus hand-computed literal checkpoints.
//   dut0: defaults (N_CH=2, RST_CYCLES=1, STAGGER=4, MAX_CYCLES=1000)
//   dut1: MAX_CYCLES=16
//   dut2: N_CH=4, RST_CYCLES=3, STAGGER=0
module tb_run_sequencer;

    localparam int P_N [3] = '{2, 2, 4};
    localparam int P_R [3] = '{1, 1, 3};
    localparam int P_S [3] = '{4, 4, 0};
    localparam int P_M [3] = '{1000, 16, 1000};

    localparam int CW0 = $clog2(1000 + 1);
    localparam int CW1 = $clog2(16 + 1);
    localparam int CW2 = $clog2(1000 + 1);

    localparam int PH_IDLE = 0;
    localparam int PH_SEQ  = 1;
    localparam int PH_END  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] reset_v, start_v, stop_v, halt_v;

    logic [1:0]     rn0, rn1;
    logic [3:0]     rn2;
    logic           run0, run1, run2;
    logic           done0, done1, done2;
    logic           to0, to1, to2;
    logic [CW0-1:0] cnt0;
    logic [CW1-1:0] cnt1;
    logic [CW2-1:0] cnt2;

    run_sequencer u_dut0 (
        .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .stop(stop_v[0]),
        .halt_req(halt_v[0]), .core_resetn(rn0), .running(run0), .done(done0),
        .timeout(to0), .cycle_count(cnt0)
    );

    run_sequencer #(
        .MAX_CYCLES(16)
    ) u_dut1 (
        .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .stop(stop_v[1]),
        .halt_req(halt_v[1]), .core_resetn(rn1), .running(run1), .done(done1),
        .timeout(to1), .cycle_count(cnt1)
    );

    run_sequencer #(
        .N_CH(4),
        .RST_CYCLES(3),
        .STAGGER(0)
    ) u_dut2 (
        .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .stop(stop_v[2]),
        .halt_req(halt_v[2]), .core_resetn(rn2), .running(run2), .done(done2),
        .timeout(to2), .cycle_count(cnt2)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int d,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Timeline model: m_t counts edges since the start edge (1 = first ASSERT
    // cycle). Channel k is free from cycle R+1+k*S; RUN begins at R+(N-1)*S+2.
    int m_ph [3];
    int m_t  [3];
    int m_cnt[3];
    bit m_done[3];
    bit m_to  [3];

    function automatic int run_start(input int d);
        return P_R[d] + (P_N[d] - 1) * P_S[d] + 2;
    endfunction

    function automatic logic [31:0] exp_rn(input int d);
        logic [31:0] r;
        r = '0;
        if (m_ph[d] == PH_SEQ && m_t[d] > P_R[d]) begin
            for (int k = 0; k < P_N[d]; k++) begin
                if (m_t[d] >= P_R[d] + 1 + k * P_S[d]) r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (reset_v[d]) begin
                m_ph[d] = PH_IDLE; m_t[d] = 0; m_cnt[d] = 0;
                m_done[d] = 1'b0; m_to[d] = 1'b0;
            end else if (stop_v[d]) begin
                m_ph[d] = PH_IDLE;
            end else if (m_ph[d] == PH_SEQ) begin
                if (m_t[d] >= run_start(d)) begin
                    if (m_cnt[d] < P_M[d]) m_cnt[d] = m_cnt[d] + 1;
                    if (halt_v[d]) begin
                        m_done[d] = 1'b1; m_ph[d] = PH_END;
                    end else if (m_cnt[d] == P_M[d]) begin
                        m_to[d] = 1'b1; m_ph[d] = PH_END;
                    end
                end
                m_t[d] = m_t[d] + 1;
            end else if (start_v[d]) begin
                m_ph[d] = PH_SEQ; m_t[d] = 1; m_cnt[d] = 0;
                m_done[d] = 1'b0; m_to[d] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                logic [31:0] a_rn, a_cnt;
                logic a_run, a_done, a_to;
                bit e_run;
                case (d)
                    0: begin a_rn = 32'(rn0); a_cnt = 32'(cnt0); a_run = run0; a_done = done0; a_to = to0; end
                    1: begin a_rn = 32'(rn1); a_cnt = 32'(cnt1); a_run = run1; a_done = done1; a_to = to1; end
                    default: begin a_rn = 32'(rn2); a_cnt = 32'(cnt2); a_run = run2; a_done = done2; a_to = to2; end
                endcase
                e_run = (m_ph[d] == PH_SEQ) && (m_t[d] >= run_start(d));
                check("model_core_resetn", d, a_rn, exp_rn(d));
                check("model_running", d, 32'(a_run), 32'(e_run));
                check("model_done", d, 32'(a_done), 32'(m_done[d]));
                check("model_timeout", d, 32'(a_to), 32'(m_to[d]));
                check("model_cycle_count", d, a_cnt, 32'(m_cnt[d]));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset_v = 3'b111; start_v = '0; stop_v = '0; halt_v = '0;
        step();
        chk_en = 1'b1;
        step();
        reset_v = '0;
        check("rst_rn", 0, 32'(rn0), 32'h0);
        check("rst_rn", 2, 32'(rn2), 32'h0);
        check("rst_cnt", 0, 32'(cnt0), 32'h0);
        check("rst_done", 1, 32'(done1), 32'h0);

        // ---- dut0: defaults, release stagger and halt after 37 RUN cycles
        start_v[0] = 1'b1; step(); start_v[0] = 1'b0;       // t=1 ASSERT
        check("a_assert_rn", 0, 32'(rn0), 32'h0);
        step();                                              // t=2 RELEASE entry
        check("a_rel_entry_rn", 0, 32'(rn0), 32'h1);
        step(3);                                             // t=5
        check("a_rel_hold_rn", 0, 32'(rn0), 32'h1);
        step();                                              // t=6
        check("a_rel_all_rn", 0, 32'(rn0), 32'h3);
        check("a_rel_not_running", 0, 32'(run0), 32'h0);
        step();                                              // t=7 RUN
        check("a_running", 0, 32'(run0), 32'h1);
        check("a_run_cnt0", 0, 32'(cnt0), 32'h0);
        step(36);
        check("a_run_cnt36", 0, 32'(cnt0), 32'd36);
        halt_v[0] = 1'b1; step(); halt_v[0] = 1'b0;
        check("a_halt_done", 0, 32'(done0), 32'h1);
        check("a_halt_timeout", 0, 32'(to0), 32'h0);
        check("a_halt_cnt", 0, 32'(cnt0), 32'd37);
        check("a_halt_rn", 0, 32'(rn0), 32'h0);
        step(3);
        stop_v[0] = 1'b1; step(); stop_v[0] = 1'b0;
        check("a_stop_keeps_done", 0, 32'(done0), 32'h1);
        check("a_stop_keeps_cnt", 0, 32'(cnt0), 32'd37);
        // halt_req outside RUN has no effect
        start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
        check("a_restart_clear_done", 0, 32'(done0), 32'h0);
        halt_v[0] = 1'b1; step(5); halt_v[0] = 1'b0;
        check("a_early_halt_ignored", 0, 32'(done0), 32'h0);
        step(3);                                             // t=9, count 2
        stop_v[0] = 1'b1; step(); stop_v[0] = 1'b0;
        check("a_stop_run_rn", 0, 32'(rn0), 32'h0);
        check("a_stop_run_cnt", 0, 32'(cnt0), 32'd2);
        // reset during RELEASE with channel 0 free
        start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
        step();
        check("a_rel_before_reset", 0, 32'(rn0), 32'h1);
        reset_v[0] = 1'b1; step(); reset_v[0] = 1'b0;
        check("a_reset_rn", 0, 32'(rn0), 32'h0);
        check("a_reset_cnt", 0, 32'(cnt0), 32'h0);
        step(3);

        // ---- dut1: MAX_CYCLES=16
        start_v[1] = 1'b1; step(); start_v[1] = 1'b0;
        step(6);
        step(15);
        check("b_cnt15", 1, 32'(cnt1), 32'd15);
        step();
        check("b_timeout", 1, 32'(to1), 32'h1);
        check("b_timeout_cnt", 1, 32'(cnt1), 32'd16);
        check("b_timeout_done", 1, 32'(done1), 32'h0);
        step(2);
        start_v[1] = 1'b1; step(); start_v[1] = 1'b0;
        check("b_restart_clear_to", 1, 32'(to1), 32'h0);
        step(6);
        step(15);
        halt_v[1] = 1'b1; step(); halt_v[1] = 1'b0;
        check("b_tie_done", 1, 32'(done1), 32'h1);
        check("b_tie_timeout", 1, 32'(to1), 32'h0);
        check("b_tie_cnt", 1, 32'(cnt1), 32'd16);
        stop_v[1] = 1'b1; start_v[1] = 1'b1; step(); stop_v[1] = 1'b0; start_v[1] = 1'b0;
        check("b_stop_over_start", 1, 32'(done1), 32'h1);
        step(2);
        reset_v[1] = 1'b1; start_v[1] = 1'b1; step(); reset_v[1] = 1'b0; start_v[1] = 1'b0;
        check("b_reset_over_start", 1, 32'(done1), 32'h0);
        step(2);

        // ---- dut2: N_CH=4, RST_CYCLES=3, STAGGER=0
        start_v[2] = 1'b1; step(); start_v[2] = 1'b0;       // t=1
        step(2);                                             // t=3
        check("c_assert_rn", 2, 32'(rn2), 32'h0);
        step();                                              // t=4
        check("c_all_release", 2, 32'(rn2), 32'hF);
        step();                                              // t=5 RUN
        check("c_running", 2, 32'(run2), 32'h1);
        step(4);
        start_v[2] = 1'b1; step(); start_v[2] = 1'b0;
        check("c_start_ignored", 2, 32'(cnt2), 32'd5);
        step(2);
        stop_v[2] = 1'b1; step(); stop_v[2] = 1'b0;
        check("c_stop_rn", 2, 32'(rn2), 32'h0);
        check("c_stop_running", 2, 32'(run2), 32'h0);
        start_v[2] = 1'b1; step(); start_v[2] = 1'b0;
        step(4);
        halt_v[2] = 1'b1; stop_v[2] = 1'b1; step(); halt_v[2] = 1'b0; stop_v[2] = 1'b0;
        check("c_stop_over_halt", 2, 32'(done2), 32'h0);
        step(3);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
